// File: rtl/fetch_pc_ctl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctl_pkg -- shared processor constants for the fetch stage.
//   PC_W           : program-counter width
//   PC_STEP        : sequential fetch increment (16-bit instructions)
//   fetchState_e   : fetch controller states (RUN / SQUASH / HALT)
//   alignPc()      : forces a target onto a halfword boundary
// ---------------------------------------------------------------------------
package fetch_pc_ctl_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] PC_STEP = 16'h0002;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        SQUASH = 2'b01,
        HALT   = 2'b10
    } fetchState_e;

    // Instructions are halfword aligned; bit 0 of any target is dropped.
    function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] target);
        return {target[PC_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/cla_16b.sv
// ---------------------------------------------------------------------------
// cla_16b -- 16-bit adder built from four 4-bit carry-lookahead groups.
//   a, b : operands        cin : carry in
//   sum  : a + b + cin (carry out discarded, so the result wraps)
// ---------------------------------------------------------------------------
module cla_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    // One 4-bit lookahead group: returns {carryOut, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       co;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & c[3]);
        return {co, p ^ c};
    endfunction

    logic [4:0] grp_s;
    logic       carry_s;

    // Chain the group carries from least to most significant nibble.
    always_comb begin
        sum     = 16'h0000;
        grp_s   = 5'b00000;
        carry_s = cin;
        for (int k = 0; k < 4; k++) begin
            grp_s          = cla4(a[k*4 +: 4], b[k*4 +: 4], carry_s);
            sum[k*4 +: 4]  = grp_s[3:0];
            carry_s        = grp_s[4];
        end
    end

endmodule

// File: rtl/fetch_pc_ctl_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg -- program-counter flop with load enable.
//   clk  : clock            rst : synchronous reset, active low
//   load : capture d        d   : next pc        q : current pc
// ---------------------------------------------------------------------------
module pc_reg
    import fetch_pc_ctl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    // PC storage: reset wins, otherwise capture only when loaded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_pc_ctl.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctl -- fetch-stage PC sequencer with redirect squash and halt.
//   clk, rst (sync, active low)
//   stall, imem_ready          : fetch hold conditions
//   branchTake/brAddr          : conditional-branch redirect
//   jumpTake/jumpAddr          : jump redirect (wins over branch)
//   halt                       : HALT reached the redirect stage
//   pc, pcPlus2                : fetch address and link value
//   fetchValid, flushIfId      : IF/ID capture / squash
//   halted (sticky), err (one-cycle pulse: branch+jump conflict or odd target)
// Optional build macro FETCH_PERF_CNT_EN adds redirCount, a saturating count
// of accepted redirects.
// ---------------------------------------------------------------------------
module fetch_pc_ctl
    import fetch_pc_ctl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 16'h0000,
    parameter int              FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            branchTake,
    input  logic [PC_W-1:0] brAddr,
    input  logic            jumpTake,
    input  logic [PC_W-1:0] jumpAddr,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pcPlus2,
    output logic            fetchValid,
    output logic            flushIfId,
    output logic            halted,
    output logic            err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]     redirCount
`endif
);

    // Extra squash cycles after the redirect cycle itself.
    localparam logic [1:0] SQ_LOAD = 2'(FLUSH_CYCLES - 1);

    fetchState_e     state_r;
    fetchState_e     state_s;
    logic [1:0]      sqCnt_r;
    logic [1:0]      sqCnt_s;
    logic            halted_r;
    logic            err_r;
    logic            redirect_s;
    logic [PC_W-1:0] target_s;
    logic            errNext_s;
    logic [PC_W-1:0] nextPc_s;
    logic            pcLoad_s;
    logic [PC_W-1:0] pcQ_s;

    pc_reg #(.RESET_PC(RESET_PC)) u_pcReg (
        .clk  (clk),
        .rst  (rst),
        .load (pcLoad_s),
        .d    (nextPc_s),
        .q    (pcQ_s)
    );

    cla_16b u_pcAdd (
        .a   (pcQ_s),
        .b   (PC_STEP),
        .cin (1'b0),
        .sum (pcPlus2)
    );

    // Redirect selection and error detection; HALT ignores all redirects.
    always_comb begin
        redirect_s = (state_r != HALT) && (jumpTake || branchTake);
        if (jumpTake) begin
            target_s = jumpAddr;
        end else begin
            target_s = brAddr;
        end
        errNext_s = redirect_s && ((jumpTake && branchTake) || target_s[0]);
    end

    // Next-state and next-pc logic.
    always_comb begin
        state_s  = state_r;
        sqCnt_s  = sqCnt_r;
        nextPc_s = pcQ_s;
        pcLoad_s = 1'b0;
        case (state_r)
            RUN, SQUASH: begin
                if (redirect_s) begin
                    pcLoad_s = 1'b1;
                    nextPc_s = alignPc(target_s);
                    if (FLUSH_CYCLES > 1) begin
                        state_s = SQUASH;
                        sqCnt_s = SQ_LOAD;
                    end else begin
                        state_s = RUN;
                        sqCnt_s = 2'd0;
                    end
                end else if (halt) begin
                    // Redirect-free halt: freeze pc and stop fetching.
                    state_s = HALT;
                    sqCnt_s = 2'd0;
                end else if (state_r == SQUASH) begin
                    // Target fetch is squashed, so pc holds until RUN.
                    if (sqCnt_r <= 2'd1) begin
                        state_s = RUN;
                        sqCnt_s = 2'd0;
                    end else begin
                        sqCnt_s = sqCnt_r - 2'd1;
                    end
                end else if (imem_ready && !stall) begin
                    pcLoad_s = 1'b1;
                    nextPc_s = pcPlus2;
                end else begin
                    pcLoad_s = 1'b0;
                end
            end
            HALT: begin
                state_s = HALT;
                sqCnt_s = 2'd0;
            end
            default: begin
                state_s = RUN;
                sqCnt_s = 2'd0;
            end
        endcase
    end

    // Control state, sticky halt flag and error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= RUN;
            sqCnt_r  <= 2'd0;
            halted_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            sqCnt_r  <= sqCnt_s;
            halted_r <= (state_s == HALT);
            err_r    <= errNext_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] redirCount_r;

    // Saturating count of accepted redirects.
    always_ff @(posedge clk) begin
        if (!rst) begin
            redirCount_r <= 16'h0000;
        end else if (redirect_s && (redirCount_r != 16'hFFFF)) begin
            redirCount_r <= redirCount_r + 16'h0001;
        end else begin
            redirCount_r <= redirCount_r;
        end
    end

    assign redirCount = redirCount_r;
`endif

    assign pc         = pcQ_s;
    assign halted     = halted_r;
    assign err        = err_r;
    assign fetchValid = rst && (state_r == RUN) && imem_ready && !stall && !redirect_s;
    assign flushIfId  = rst && (redirect_s || (state_r == SQUASH));

endmodule
